// File: rtl/tone_sequencer.sv
// Note-table sequencer for the square-wave tone generator.
// Holds a DEPTH-entry table of {period, volume, duration} records, plays each
// entry for duration*TICK_DIV clock cycles, then inserts a silent gap of
// GAP_TICKS*TICK_DIV cycles before stepping to the next entry. An entry with
// duration 0 (or the last table slot) ends the sequence, or wraps to entry 0
// when loop is held high.
module tone_sequencer #(
  parameter int          DEPTH          = 16,
  parameter int          AW             = 4,
  parameter int          TICK_DIV       = 50000,
  parameter int          GAP_TICKS      = 1,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd14205
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [15:0]   period,
  output logic [7:0]    volume,
  output logic          playing,
  output logic [AW-1:0] note_idx,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_END
  } state_t;

  // Prescaler width covers 0..TICK_DIV-1; keep at least one bit when TICK_DIV is 1.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Tick counter must hold both an 8-bit note duration and the gap length.
  localparam int TW = ($clog2(GAP_TICKS + 1) > 8) ? $clog2(GAP_TICKS + 1) : 8;

  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_TICKS);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);

  // Registered state
  state_t          state;
  logic [PW-1:0]   prescaler;
  logic [TW-1:0]   tick_cnt;

  // Next-state values
  state_t          state_n;
  logic [15:0]     period_n;
  logic [7:0]      volume_n;
  logic            playing_n;
  logic [AW-1:0]   note_idx_n;
  logic            done_n;
  logic [PW-1:0]   prescaler_n;
  logic [TW-1:0]   tick_cnt_n;

  // Transition helpers
  logic            tick;
  logic            advance;
  logic            load_req;
  logic [AW-1:0]   load_idx;
  logic            end_req;
  logic            play_req;
  logic [AW-1:0]   play_idx;
  logic [31:0]     play_entry;
  logic [31:0]     entry_sel;
  logic [31:0]     entry_zero;

  logic [31:0]     note_table [DEPTH];

  assign tick = (prescaler == PRE_MAX);

  // Note table: synchronous write, combinational read (a same-cycle load sees old data).
  // NOTE: the table has no reset; it is plain storage and must survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      note_table[wr_addr] <= wr_data;
    end
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      period    <= DEFAULT_PERIOD;
      volume    <= '0;
      playing   <= 1'b0;
      note_idx  <= '0;
      done      <= 1'b0;
      prescaler <= '0;
      tick_cnt  <= '0;
    end else begin
      state     <= state_n;
      period    <= period_n;
      volume    <= volume_n;
      playing   <= playing_n;
      note_idx  <= note_idx_n;
      done      <= done_n;
      prescaler <= prescaler_n;
      tick_cnt  <= tick_cnt_n;
    end
  end

  // Next-state logic: timing in PLAY/GAP, the combinational ADVANCE step,
  // Load() resolution including end-marker handling, then start/stop overrides.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_n     = state;
    period_n    = period;
    volume_n    = volume;
    playing_n   = playing;
    note_idx_n  = note_idx;
    done_n      = 1'b0;
    prescaler_n = prescaler;
    tick_cnt_n  = tick_cnt;
    advance     = 1'b0;
    load_req    = 1'b0;
    load_idx    = '0;
    end_req     = 1'b0;
    play_req    = 1'b0;
    play_idx    = '0;
    play_entry  = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          load_req = 1'b1;
        end
      end
      S_PLAY: begin
        prescaler_n = tick ? '0 : prescaler + 1'b1;
        if (tick) begin
          tick_cnt_n = tick_cnt - 1'b1;
          if (tick_cnt == CNT_ONE) begin
            if (GAP_TICKS > 0) begin
              state_n    = S_GAP;
              volume_n   = '0;
              tick_cnt_n = GAP_LOAD;
            end else begin
              advance = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        prescaler_n = tick ? '0 : prescaler + 1'b1;
        if (tick) begin
          tick_cnt_n = tick_cnt - 1'b1;
          if (tick_cnt == CNT_ONE) begin
            advance = 1'b1;
          end
        end
      end
      S_END: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // ADVANCE: step forward, wrap when looping, or finish at the last slot.
    if (advance) begin
      if (note_idx != LAST_IDX) begin
        load_req = 1'b1;
        load_idx = note_idx + 1'b1;
      end else if (loop) begin
        load_req = 1'b1;
      end else begin
        end_req = 1'b1;
      end
    end

    // A start while a sequence is running restarts it from entry 0.
    if (start && (state == S_PLAY || state == S_GAP)) begin
      load_req = 1'b1;
      load_idx = '0;
      end_req  = 1'b0;
    end

    // Load(): an end marker wraps to entry 0 when looping from a nonzero
    // index; a marker at entry 0 always ends the sequence.
    entry_sel  = note_table[load_idx];
    entry_zero = note_table[0];
    if (load_req) begin
      if (entry_sel[7:0] != 8'd0) begin
        play_req   = 1'b1;
        play_idx   = load_idx;
        play_entry = entry_sel;
      end else if (loop && load_idx != '0 && entry_zero[7:0] != 8'd0) begin
        play_req   = 1'b1;
        play_idx   = '0;
        play_entry = entry_zero;
      end else begin
        end_req    = 1'b1;
        note_idx_n = (loop && load_idx != '0) ? '0 : load_idx;
      end
    end

    if (play_req) begin
      state_n     = S_PLAY;
      note_idx_n  = play_idx;
      period_n    = play_entry[31:16];
      volume_n    = play_entry[15:8];
      tick_cnt_n  = TW'(play_entry[7:0]);
      prescaler_n = '0;
      playing_n   = 1'b1;
    end

    if (end_req) begin
      state_n     = S_END;
      volume_n    = '0;
      playing_n   = 1'b0;
      done_n      = 1'b1;
      prescaler_n = '0;
    end

    // stop beats everything, including a simultaneous start.
    if (stop) begin
      state_n     = S_IDLE;
      volume_n    = '0;
      playing_n   = 1'b0;
      done_n      = 1'b0;
      prescaler_n = '0;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed testbench for tone_sequencer with TICK_DIV=4, GAP_TICKS=1, DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so each check sees the result of the edge just passed.
module tb_tone_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          start;
  logic          stop;
  logic          loop;
  logic [15:0]   period;
  logic [7:0]    volume;
  logic          playing;
  logic [AW-1:0] note_idx;
  logic          done;

  int n_cmp;
  int n_err;

  tone_sequencer #(
    .DEPTH         (DEPTH),
    .AW            (AW),
    .TICK_DIV      (4),
    .GAP_TICKS     (1),
    .DEFAULT_PERIOD(16'd14205)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .period  (period),
    .volume  (volume),
    .playing (playing),
    .note_idx(note_idx),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [15:0] p,
                             input logic [7:0] v, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {p, v, d};
    cycles(1);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
  endtask

  task automatic check_note(input string tag, input logic [15:0] p, input logic [7:0] v,
                            input logic [AW-1:0] i);
    check({tag, ".period"}, period, p);
    check({tag, ".volume"}, volume, v);
    check({tag, ".idx"}, note_idx, i);
    check({tag, ".playing"}, playing, 1);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    stop    = 1'b0;
    loop    = 1'b0;

    // 1: reset values
    cycles(2);
    check("rst.period", period, 14205);
    check("rst.volume", volume, 0);
    check("rst.playing", playing, 0);
    check("rst.done", done, 0);
    check("rst.idx", note_idx, 0);
    rst_n = 1'b1;
    cycles(1);

    // 2: basic two-note sequence ending on a marker
    write_entry(0, 100, 200, 2);
    write_entry(1, 50, 128, 1);
    write_entry(2, 0, 0, 0);
    pulse_start();                       // edge k
    check_note("t2.e0", 100, 200, 0);
    cycles(7);                           // k+7: last cycle of e0
    check("t2.e0_end.volume", volume, 200);
    cycles(1);                           // k+8: gap begins
    check("t2.gap0.volume", volume, 0);
    check("t2.gap0.period", period, 100);
    check("t2.gap0.playing", playing, 1);
    cycles(3);                           // k+11
    check("t2.gap0_end.volume", volume, 0);
    cycles(1);                           // k+12
    check_note("t2.e1", 50, 128, 1);
    cycles(3);                           // k+15
    check("t2.e1_end.volume", volume, 128);
    cycles(1);                           // k+16
    check("t2.gap1.volume", volume, 0);
    cycles(3);                           // k+19
    check("t2.gap1_end.done", done, 0);
    cycles(1);                           // k+20
    check("t2.done", done, 1);
    check("t2.end.playing", playing, 0);
    check("t2.end.idx", note_idx, 2);
    check("t2.end.volume", volume, 0);
    check("t2.end.period", period, 50);
    cycles(1);
    check("t2.done_pulse", done, 0);

    // 3a: loop wraps at the marker instead of finishing
    loop = 1'b1;
    pulse_start();
    cycles(19);                          // k+19
    check("t3.gap1.done", done, 0);
    cycles(1);                           // k+20
    check_note("t3.wrap", 100, 200, 0);
    check("t3.wrap.done", done, 0);
    pulse_stop();
    loop = 1'b0;
    check("t3.stop.playing", playing, 0);

    // 3b: full table, sequence ends after the last slot
    write_entry(2, 300, 10, 1);
    write_entry(3, 400, 20, 1);
    pulse_start();                       // k
    cycles(20);                          // k+20
    check_note("t3.e2", 300, 10, 2);
    cycles(8);                           // k+28
    check_note("t3.e3", 400, 20, 3);
    cycles(7);                           // k+35
    check("t3.e3_gap.done", done, 0);
    cycles(1);                           // k+36
    check("t3.full.done", done, 1);
    check("t3.full.idx", note_idx, 3);
    check("t3.full.playing", playing, 0);
    cycles(1);
    check("t3.full.done_pulse", done, 0);

    // 4: stop mid-note, then start+stop together in IDLE
    pulse_start();                       // k
    cycles(2);                           // k+2
    pulse_stop();                        // stop sampled at k+3
    check("t4.stop.volume", volume, 0);
    check("t4.stop.playing", playing, 0);
    check("t4.stop.done", done, 0);
    check("t4.stop.period", period, 100);
    check("t4.stop.idx", note_idx, 0);
    cycles(1);
    check("t4.stop.no_done", done, 0);
    start = 1'b1;
    stop  = 1'b1;
    cycles(1);
    start = 1'b0;
    stop  = 1'b0;
    check("t4.both.playing", playing, 0);
    check("t4.both.volume", volume, 0);
    cycles(2);
    check("t4.both.idle", playing, 0);

    // 5: rewrite e1 while e0 plays; then end marker at entry 0
    pulse_start();                       // k
    cycles(2);                           // k+2
    write_entry(1, 77, 9, 1);            // written at k+3
    cycles(9);                           // k+12
    check_note("t5.e1_new", 77, 9, 1);
    pulse_stop();
    write_entry(0, 100, 200, 0);
    loop = 1'b1;                         // marker at entry 0 ends even when looping
    pulse_start();
    check("t5.marker0.done", done, 1);
    check("t5.marker0.volume", volume, 0);
    check("t5.marker0.playing", playing, 0);
    check("t5.marker0.idx", note_idx, 0);
    cycles(1);
    check("t5.marker0.done_pulse", done, 0);
    check("t5.marker0.vol_hold", volume, 0);
    loop = 1'b0;

    // 6: reset during GAP keeps the table
    write_entry(0, 100, 200, 2);
    pulse_start();                       // k
    cycles(9);                           // k+9, in gap
    check("t6.gap.volume", volume, 0);
    check("t6.gap.playing", playing, 1);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    check("t6.rst.period", period, 14205);
    check("t6.rst.volume", volume, 0);
    check("t6.rst.playing", playing, 0);
    check("t6.rst.idx", note_idx, 0);
    check("t6.rst.done", done, 0);
    pulse_start();                       // k
    check_note("t6.replay.e0", 100, 200, 0);
    cycles(12);                          // k+12
    check_note("t6.replay.e1", 77, 9, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
